// File: rtl/uart_pkg.sv
// Constants and FSM encoding shared by the UART blocks (uart_tx, uart_rx, uart_tx_arb).
package uart_pkg;

  localparam int UART_NREQ        = 4;
  localparam int UART_CLK_PER_BIT = 5208;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

  function automatic logic [UART_NREQ-1:0] id_onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin picker: first set req bit at or above ptr, wrapping 3 -> 0.
module rr_arb4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_id,
  output logic       any
);

  always_comb begin
    gnt_id = 2'd0;
    any    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      // 2-bit sum wraps naturally, giving the circular search order.
      if (!any && req[ptr + 2'(i)]) begin
        gnt_id = ptr + 2'(i);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx among NREQ requesters; grant seen at edge N launches in cycle N+1.
// Requests wait while tx_busy is high; a frame ends on tx_done or a watchdog timeout (byte dropped).
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NREQ        = UART_NREQ,
  parameter int CLK_PER_BIT = UART_CLK_PER_BIT,
  parameter int TIMEOUT     = 11 * CLK_PER_BIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  input  logic              tx_done,
  output logic [1:0]        grant_id,
  output logic              active,
  output logic              tx_err
);

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  arb_state_e  state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  grant_q, grant_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] wdog_q, wdog_d;
  logic        err_q, err_d;

  logic [1:0]  pick_id;
  logic        pick_any;

  rr_arb4 u_pick (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt_id (pick_id),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    wdog_d  = wdog_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any && !tx_busy) begin
          state_d = ST_LAUNCH;
          grant_d = pick_id;
          data_d  = req_data[{pick_id, 3'b000} +: 8];
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT_DONE;
        wdog_d  = 16'd0;
      end
      ST_WAIT_DONE: begin
        // tx_done takes priority over an expiring watchdog in the same cycle.
        if (tx_done) begin
          state_d = ST_IDLE;
          ptr_d   = grant_q + 2'd1;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = ST_IDLE;
          ptr_d   = grant_q + 2'd1;
          err_d   = 1'b1;
        end else begin
          wdog_d  = wdog_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      grant_q <= 2'd0;
      data_q  <= 8'h00;
      wdog_q  <= 16'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      wdog_q  <= wdog_d;
      err_q   <= err_d;
    end
  end

  assign tx_start  = (state_q == ST_LAUNCH);
  assign req_ready = tx_start ? id_onehot(grant_q) : '0;
  assign tx_data   = data_q;
  assign grant_id  = grant_q;
  assign active    = (state_q != ST_IDLE);
  assign tx_err    = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb with a scoreboard of expected grants checked at each tx_start.
module tb_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        tx_done;
  logic [1:0]  grant_id;
  logic        active;
  logic        tx_err;

  typedef struct {
    logic [1:0] id;
    logic [7:0] dat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   n_starts = 0;
  logic prev_start = 1'b0;
  logic bad;

  always #5 clk = ~clk;

  uart_tx_arb #(.TIMEOUT(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done),
    .grant_id  (grant_id),
    .active    (active),
    .tx_err    (tx_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] dat);
    exp_t e;
    e.id  = id;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int k;
    k = 0;
    while (!tx_start && k < 50) begin
      step();
      k++;
    end
    check(tag, 32'(tx_start), 32'd1);
  endtask

  // Scoreboard side: every launch must match the oldest expected grant.
  always @(negedge clk) begin
    if (rst && tx_start) begin
      n_starts++;
      n_tests++;
      assert (!prev_start) else begin
        n_fail++;
        $error("FAIL start_width: tx_start observed high 2 cycles, expected 1");
      end
      n_tests++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL unexpected_start: observed launch grant %0d, expected none", grant_id);
      end
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("sb_grant", 32'(grant_id), 32'(mon_e.id));
        check("sb_data", 32'(tx_data), 32'(mon_e.dat));
        check("sb_ready", 32'(req_ready), 32'(4'b0001 << mon_e.id));
      end
    end
    prev_start = tx_start;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = 4'b0000;
    req_data  = 32'h0;
    tx_busy   = 1'b0;
    tx_done   = 1'b0;
    rst       = 1'b0;
    repeat (2) step();
    check("rst_start", 32'(tx_start), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_data", 32'(tx_data), 32'h00);
    check("rst_active", 32'(active), 32'd0);
    check("rst_err", 32'(tx_err), 32'd0);
    rst = 1'b1;
    step();

    // Single request: launch one cycle after being seen.
    req_data  = 32'h0000_0055;
    req_valid = 4'b0001;
    push(2'd0, 8'h55);
    step();
    check("single_start", 32'(tx_start), 32'd1);
    check("single_ready", 32'(req_ready), 32'h1);
    check("single_data", 32'(tx_data), 32'h55);
    check("single_grant", 32'(grant_id), 32'd0);
    check("single_active", 32'(active), 32'd1);
    req_valid = 4'b0000;
    step();
    check("wait_start_low", 32'(tx_start), 32'd0);
    check("wait_ready_low", 32'(req_ready), 32'd0);
    check("wait_active", 32'(active), 32'd1);
    pulse_done();
    check("done_idle", 32'(active), 32'd0);
    check("done_no_err", 32'(tx_err), 32'd0);

    // Rotation with all four requesting from a fresh pointer.
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    req_data  = 32'hA3A2_A1A0;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      push(2'(i % 4), 8'(8'hA0 + i % 4));
      wait_start("rot_start");
      step();
      pulse_done();
    end
    req_valid = 4'b0000;

    // tx_busy holds off the launch.
    tx_busy   = 1'b1;
    req_data  = 32'h003C_0000;
    req_valid = 4'b0100;
    bad = 1'b0;
    repeat (6) begin
      step();
      if (tx_start || active) bad = 1'b1;
    end
    check("busy_hold", 32'(bad), 32'd0);
    tx_busy = 1'b0;
    push(2'd2, 8'h3C);
    step();
    check("busy_release_lat", 32'(tx_start), 32'd1);
    req_valid = 4'b0000;
    step();
    pulse_done();

    // Watchdog expiry: error 100 cycles after leaving LAUNCH.
    req_data  = 32'h0000_8100;
    req_valid = 4'b0010;
    push(2'd1, 8'h81);
    wait_start("to_start");
    req_valid = 4'b0000;
    bad = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (tx_err || !active) bad = 1'b1;
    end
    check("to_early", 32'(bad), 32'd0);
    step();
    check("to_err", 32'(tx_err), 32'd1);
    check("to_idle", 32'(active), 32'd0);
    step();
    check("to_err_pulse", 32'(tx_err), 32'd0);

    // Pointer after timeout is grant+1 = 2.
    req_data  = 32'h00C4_0011;
    req_valid = 4'b0101;
    push(2'd2, 8'hC4);
    wait_start("after_to_start");
    req_valid = 4'b0000;

    // tx_done coincident with expiry: no error.
    bad = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (tx_err || !active) bad = 1'b1;
    end
    check("coin_pre", 32'(bad), 32'd0);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check("coin_no_err", 32'(tx_err), 32'd0);
    check("coin_idle", 32'(active), 32'd0);
    step();
    check("coin_no_err_late", 32'(tx_err), 32'd0);

    // Stray tx_done in IDLE is ignored.
    pulse_done();
    check("stray_done", {30'd0, active, tx_err}, 32'd0);

    // Reset in WAIT_DONE with grant 2.
    req_data  = 32'h0077_0000;
    req_valid = 4'b0100;
    push(2'd2, 8'h77);
    wait_start("rst_start_pre");
    req_valid = 4'b0000;
    step();
    check("pre_rst_grant", 32'(grant_id), 32'd2);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_active", 32'(active), 32'd0);
    check("mid_rst_start", 32'(tx_start), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_grant", 32'(grant_id), 32'd0);
    check("mid_rst_data", 32'(tx_data), 32'h00);
    check("mid_rst_err", 32'(tx_err), 32'd0);
    step();
    rst       = 1'b1;
    req_data  = 32'h9988_0000;
    req_valid = 4'b1100;
    push(2'd2, 8'h88);
    wait_start("post_rst_start");
    check("post_rst_grant", 32'(grant_id), 32'd2);
    req_valid = 4'b0000;
    step();
    pulse_done();
    step();

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("start_count", 32'(n_starts), 32'd11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one uart_tx (fixed 4 in this revision).
REQ-002 Parameter CLK_PER_BIT, default 5208: must match uart_tx baud divisor.
REQ-003 Parameter TIMEOUT, default 11*CLK_PER_BIT: max cycles from tx_start to tx_done.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  4  bit i: requester i holds a byte to send.
REQ-007 req_data  input  32  byte i at bits [8i+7:8i]; stable while req_valid[i] high.
REQ-008 req_ready  output  4  one-cycle pulse on bit i: byte i accepted.
REQ-009 tx_start  output  1  one-cycle launch pulse to uart_tx.
REQ-010 tx_data  output  8  byte to uart_tx; stable from launch until return to IDLE.
REQ-011 tx_busy  input  1  uart_tx frame in progress.
REQ-012 tx_done  input  1  uart_tx one-cycle frame-complete pulse.
REQ-013 grant_id  output  2  index of current/last granted requester.
REQ-014 active  output  1  high in LAUNCH and WAIT_DONE.
REQ-015 tx_err  output  1  one-cycle pulse: frame timed out.

Function
REQ-016 FSM states IDLE, LAUNCH, WAIT_DONE; one-hot or binary encoding at implementer's choice.
REQ-017 IDLE -> LAUNCH when any req_valid high and tx_busy low; otherwise remain IDLE.
REQ-018 On that transition: register grant_id = first requester with req_valid high, searching round-robin from rr_ptr upward, wrapping 3 -> 0; register tx_data = that requester's byte.
REQ-019 LAUNCH lasts exactly one cycle: tx_start = 1, req_ready[grant_id] = 1, all other req_ready bits 0; then -> WAIT_DONE.
REQ-020 Latency: request seen in IDLE at edge N -> tx_start and req_ready high in cycle N+1.
REQ-021 WAIT_DONE: 16-bit watchdog counts from 0 each cycle; tx_done -> IDLE, rr_ptr = grant_id+1 (mod 4).
REQ-022 Watchdog reaching TIMEOUT-1 without tx_done -> tx_err = 1 for one cycle, IDLE, rr_ptr = grant_id+1 (mod 4); byte is dropped, not retried.
REQ-023 tx_done and timeout in same cycle: tx_done wins, no tx_err.
REQ-024 tx_done outside WAIT_DONE is ignored.
REQ-025 req_valid deasserted by requester before grant: no grant; arbiter holds no per-requester state.
REQ-026 Minimum gap: one IDLE cycle between consecutive frames; back-to-back requesters served in rotation, no requester starved beyond 3 frames.
REQ-027 tx_start, req_ready, tx_err never high outside the cycles stated above.

Reset
REQ-028 rst low asynchronously forces: state IDLE, rr_ptr 0, grant_id 0, tx_data 0x00, watchdog 0, tx_start 0, req_ready 0, tx_err 0, active 0.
REQ-029 Reset mid-frame: no completion or error reported; the in-flight byte is lost; first grant after release starts search at requester 0.

Structure
REQ-030 Shared package uart_pkg holds CLK_PER_BIT default, FSM state encoding, and NREQ constant, shared with uart_tx/uart_rx.
REQ-031 One sub-module rr_arb4: combinational 4-way round-robin picker (req[3:0], ptr[1:0] -> gnt_id[1:0], any); FSM and watchdog stay in uart_tx_arb.

Verification
REQ-032 Single request: req_valid=0001, data0=0x55, tx_busy=0 -> tx_start and req_ready=0001 one cycle later, tx_data=0x55, grant_id=0.
REQ-033 All four valid continuously, data 0xA0..0xA3, tx_done pulsed each frame -> grant order 0,1,2,3,0, tx_data order 0xA0,0xA1,0xA2,0xA3,0xA0.
REQ-034 tx_busy held 1 with req_valid=0100 -> no tx_start until tx_busy falls; tx_start then exactly one cycle after.
REQ-035 TIMEOUT=100 override, no tx_done -> tx_err pulse 100 cycles after LAUNCH exit, state IDLE, next grant starts search at grant_id+1.
REQ-036 tx_done and watchdog expiry coincident -> IDLE, tx_err stays 0.
REQ-037 rst low during WAIT_DONE with grant_id=2 -> all outputs at reset values immediately; after release with req_valid=1100, grant_id=2.
